// File: rtl/palette_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : palette_arb_pkg
//  Purpose  : Shared widths, host FSM states and helpers for the palette
//             access arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package palette_arb_pkg;

   localparam int LAYER_W     = 5;
   localparam int COLOR_W     = 5;
   localparam int RGB888_W    = 24;
   localparam int HOST_DATA_W = 16;

   // Streak counter must hold HOST_SLOT_INTERVAL up to 255.
   localparam int c_STREAK_W  = 8;
   localparam int c_STAT_W    = 16;

   typedef enum logic [1:0] {
      H_IDLE = 2'd0,
      H_WR   = 2'd1,
      H_RD1  = 2'd2,
      H_RD2  = 2'd3
   } hostState_t;

   function automatic logic [c_STAT_W-1:0] satInc(input logic [c_STAT_W-1:0] value);
      return (&value) ? value : value + c_STAT_W'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/palette_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : palette_arb_starve_ctr
//  Purpose  : Counts pipeline grants while the host waits during active video
//             and forces a host slot once the streak limit is reached.
//  Revision : 1.0 - initial release
// ============================================================================
module palette_arb_starve_ctr
   import palette_arb_pkg::*;
#(
   parameter int HOST_SLOT_INTERVAL = 8
) (
   input  logic clk_pipe,
   input  logic rst,
   input  logic blanking,
   input  logic hostPending,
   input  logic pipeGrant,
   input  logic hostGrant,
   output logic forceHost
);

   localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(HOST_SLOT_INTERVAL);

   logic [c_STREAK_W-1:0] r_streak;

   generate
      if ((HOST_SLOT_INTERVAL < 1) || (HOST_SLOT_INTERVAL > 255)) begin : g_intervalCheck
         $error("palette_arb_starve_ctr: HOST_SLOT_INTERVAL must be 1..255");
      end
   endgenerate

   always_ff @(posedge clk_pipe or posedge rst) begin
      if (rst) begin
         r_streak <= '0;
      end else if (hostGrant || !hostPending) begin
         r_streak <= '0;
      end else if (pipeGrant && !blanking && (r_streak != c_STREAK_MAX)) begin
         r_streak <= r_streak + c_STREAK_W'(1);
      end
   end

   assign forceHost = blanking || (r_streak == c_STREAK_MAX);

endmodule
`default_nettype wire

// File: rtl/palette_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : palette_access_arbiter
//  Purpose  : Shares the single-port palette memory between pipeline colour
//             lookups and host register accesses. Optional stall statistics
//             are built when PALETTE_ARB_STATS_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module palette_access_arbiter
   import palette_arb_pkg::*;
#(
   parameter int HOST_SLOT_INTERVAL = 8,
   parameter int MEM_RD_LATENCY     = 1
) (
   input  logic                   clk_pipe,
   input  logic                   rst,
   input  logic                   blanking,
   input  logic                   pipeReq,
   input  logic [LAYER_W-1:0]     pipeLayer,
   input  logic [COLOR_W-1:0]     pipeColor,
   output logic                   pipeGrant,
   output logic                   pipeDataValid,
   output logic [RGB888_W-1:0]    pipeData,
   input  logic                   hostReq,
   input  logic                   hostWrite,
   input  logic [LAYER_W-1:0]     hostLayer,
   input  logic [COLOR_W-1:0]     hostColor,
   input  logic                   hostRGB,
   input  logic [HOST_DATA_W-1:0] hostWriteData,
   output logic                   hostAck,
   output logic [HOST_DATA_W-1:0] hostReadData,
   output logic [LAYER_W-1:0]     memLayer,
   output logic [COLOR_W-1:0]     memColor,
   output logic                   memRGB,
   output logic                   memWriteEn,
   output logic [HOST_DATA_W-1:0] memWriteData,
   input  logic [RGB888_W-1:0]    memRdData24,
   input  logic [HOST_DATA_W-1:0] memRdData16,
   output logic [c_STAT_W-1:0]    statStallCount
);

   hostState_t            r_hostState;
   hostState_t            w_hostStateNext;
   logic                  w_hostAck;
   logic                  w_hostCand;
   logic                  w_forceHost;
   logic                  w_hostWin;
   logic                  w_pipeWin;
   logic                  r_pipeTag1;
   logic                  r_pipeTag2;
   logic [RGB888_W-1:0]   r_pipeDataHold;
   logic [HOST_DATA_W-1:0] r_hostReadHold;

   generate
      if (MEM_RD_LATENCY != 1) begin : g_latencyCheck
         $error("palette_access_arbiter: only MEM_RD_LATENCY = 1 is supported");
      end
   endgenerate

   // A host access in flight is not a candidate again until the FSM is idle.
   assign w_hostCand = hostReq && (r_hostState == H_IDLE);
   assign w_hostWin  = w_hostCand && (!pipeReq || w_forceHost);
   assign w_pipeWin  = pipeReq && !w_hostWin;
   assign pipeGrant  = w_pipeWin;

   palette_arb_starve_ctr #(
      .HOST_SLOT_INTERVAL (HOST_SLOT_INTERVAL)
   ) u_starveCtr (
      .clk_pipe    (clk_pipe),
      .rst         (rst),
      .blanking    (blanking),
      .hostPending (w_hostCand),
      .pipeGrant   (w_pipeWin),
      .hostGrant   (w_hostWin),
      .forceHost   (w_forceHost)
   );

   always_ff @(posedge clk_pipe or posedge rst) begin
      if (rst) begin
         r_hostState <= H_IDLE;
      end else begin
         r_hostState <= w_hostStateNext;
      end
   end

   always_comb begin
      w_hostStateNext = r_hostState;
      w_hostAck       = 1'b0;
      case (r_hostState)
         H_IDLE: begin
            if (w_hostWin) begin
               w_hostStateNext = hostWrite ? H_WR : H_RD1;
            end
         end
         H_WR: begin
            w_hostAck       = 1'b1;
            w_hostStateNext = H_IDLE;
         end
         H_RD1: begin
            w_hostStateNext = H_RD2;
         end
         H_RD2: begin
            w_hostAck       = 1'b1;
            w_hostStateNext = H_IDLE;
         end
         default: begin
            w_hostStateNext = H_IDLE;
         end
      endcase
   end

   assign hostAck = w_hostAck;

   // Address/control issue register; address holds on idle cycles.
   always_ff @(posedge clk_pipe or posedge rst) begin
      if (rst) begin
         memLayer     <= '0;
         memColor     <= '0;
         memRGB       <= 1'b0;
         memWriteEn   <= 1'b0;
         memWriteData <= '0;
      end else begin
         memWriteEn <= 1'b0;
         if (w_pipeWin) begin
            memLayer <= pipeLayer;
            memColor <= pipeColor;
            memRGB   <= 1'b0;
         end else if (w_hostWin) begin
            memLayer   <= hostLayer;
            memColor   <= hostColor;
            memRGB     <= hostRGB;
            memWriteEn <= hostWrite;
            if (hostWrite) begin
               memWriteData <= hostWriteData;
            end
         end
      end
   end

   // Tag follows the address one stage behind, lining up with read data.
   always_ff @(posedge clk_pipe or posedge rst) begin
      if (rst) begin
         r_pipeTag1     <= 1'b0;
         r_pipeTag2     <= 1'b0;
         r_pipeDataHold <= '0;
         r_hostReadHold <= '0;
      end else begin
         r_pipeTag1 <= w_pipeWin;
         r_pipeTag2 <= r_pipeTag1;
         if (r_pipeTag2) begin
            r_pipeDataHold <= memRdData24;
         end
         if (r_hostState == H_RD2) begin
            r_hostReadHold <= memRdData16;
         end
      end
   end

   assign pipeDataValid = r_pipeTag2;
   assign pipeData      = r_pipeTag2 ? memRdData24 : r_pipeDataHold;
   assign hostReadData  = (r_hostState == H_RD2) ? memRdData16 : r_hostReadHold;

`ifdef PALETTE_ARB_STATS_EN
   logic [c_STAT_W-1:0] r_stallCount;

   always_ff @(posedge clk_pipe or posedge rst) begin
      if (rst) begin
         r_stallCount <= '0;
      end else if (pipeReq && !w_pipeWin) begin
         r_stallCount <= satInc(r_stallCount);
      end
   end

   assign statStallCount = r_stallCount;
`else
   assign statStallCount = '0;
`endif

endmodule
`default_nettype wire
